// File: rtl/poly_eval_driver.sv
// Host-side initiator for the 8-bit polynomial evaluator: latches one operand set,
// serialises A, B, C, X onto the Go/DataIn load interface, then captures DataResult.
module poly_eval_driver #(
   parameter int DATA_W         = 8,
   parameter int GO_HIGH_CYCLES = 2,
   parameter int GO_LOW_CYCLES  = 1,
   parameter int RESULT_LATENCY = 6
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              start,
   input  logic [DATA_W-1:0] a_in,
   input  logic [DATA_W-1:0] b_in,
   input  logic [DATA_W-1:0] c_in,
   input  logic [DATA_W-1:0] x_in,
   output logic              busy,
   output logic              done,
   output logic [DATA_W-1:0] result,
   output logic              eval_go,
   output logic [DATA_W-1:0] eval_data,
   input  logic [DATA_W-1:0] eval_result
);

   localparam logic [3:0] HI_LAST  = 4'(GO_HIGH_CYCLES - 1);
   localparam logic [3:0] LO_LAST  = 4'(GO_LOW_CYCLES - 1);
   localparam logic [3:0] RES_LAST = 4'(RESULT_LATENCY - 1);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      DRIVE_HI = 3'd1,
      DRIVE_LO = 3'd2,
      WAIT_RES = 3'd3,
      CAPTURE  = 3'd4
   } state_t;

   state_t            state, state_nxt;
   logic [1:0]        idx, idx_nxt;
   logic [3:0]        cnt, cnt_nxt;
   logic [DATA_W-1:0] op     [4];
   logic [DATA_W-1:0] op_nxt [4];
   logic              busy_nxt, done_nxt, go_nxt;
   logic [DATA_W-1:0] data_nxt, result_nxt;

   // All outputs are registered from next-state values so Go and DataIn never glitch.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state     <= IDLE;
         idx       <= '0;
         cnt       <= '0;
         for (int i = 0; i < 4; i++) op[i] <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         eval_go   <= 1'b0;
         eval_data <= '0;
         result    <= '0;
      end else begin
         state     <= state_nxt;
         idx       <= idx_nxt;
         cnt       <= cnt_nxt;
         for (int i = 0; i < 4; i++) op[i] <= op_nxt[i];
         busy      <= busy_nxt;
         done      <= done_nxt;
         eval_go   <= go_nxt;
         eval_data <= data_nxt;
         result    <= result_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      idx_nxt    = idx;
      cnt_nxt    = cnt;
      for (int i = 0; i < 4; i++) op_nxt[i] = op[i];
      busy_nxt   = busy;
      done_nxt   = 1'b0;
      result_nxt = result;
      go_nxt     = 1'b0;
      data_nxt   = '0;

      case (state)
         IDLE: begin
            if (start) begin
               op_nxt[0] = a_in;
               op_nxt[1] = b_in;
               op_nxt[2] = c_in;
               op_nxt[3] = x_in;
               idx_nxt   = 2'd0;
               cnt_nxt   = 4'd0;
               busy_nxt  = 1'b1;
               state_nxt = DRIVE_HI;
            end
         end
         DRIVE_HI: begin
            if (cnt == HI_LAST) begin
               cnt_nxt   = 4'd0;
               state_nxt = DRIVE_LO;
            end else begin
               cnt_nxt = cnt + 4'd1;
            end
         end
         DRIVE_LO: begin
            if (cnt == LO_LAST) begin
               cnt_nxt = 4'd0;
               if (idx == 2'd3) begin
                  state_nxt = WAIT_RES;
               end else begin
                  idx_nxt   = idx + 2'd1;
                  state_nxt = DRIVE_HI;
               end
            end else begin
               cnt_nxt = cnt + 4'd1;
            end
         end
         WAIT_RES: begin
            // Result is sampled on the edge entering CAPTURE so it is valid alongside done.
            if (cnt == RES_LAST) begin
               cnt_nxt    = 4'd0;
               result_nxt = eval_result;
               busy_nxt   = 1'b0;
               done_nxt   = 1'b1;
               state_nxt  = CAPTURE;
            end else begin
               cnt_nxt = cnt + 4'd1;
            end
         end
         CAPTURE: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase

      go_nxt = (state_nxt == DRIVE_HI);
      if (state_nxt == DRIVE_HI || state_nxt == DRIVE_LO) begin
         data_nxt = op_nxt[idx_nxt];
      end
   end

endmodule

// File: tb/tb_poly_eval_driver.sv
// Bench for poly_eval_driver: behavioural evaluator stand-in, table vectors,
// hand-written corner sequences and random transactions against plain arithmetic.
module tb_poly_eval_driver;

   localparam int HI  = 2;
   localparam int LO  = 1;
   localparam int LAT = 6;
   localparam int PER = HI + LO;
   localparam int TOTAL = 4 * PER + LAT + 1;

   logic       clk = 1'b0;
   logic       resetn = 1'b0;
   logic       start = 1'b0;
   logic [7:0] a_in = '0, b_in = '0, c_in = '0, x_in = '0;
   logic       busy, done, eval_go;
   logic [7:0] result, eval_data;
   logic [7:0] eval_result;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   poly_eval_driver #(
      .DATA_W(8), .GO_HIGH_CYCLES(HI), .GO_LOW_CYCLES(LO), .RESULT_LATENCY(LAT)
   ) dut (
      .clk(clk), .resetn(resetn), .start(start),
      .a_in(a_in), .b_in(b_in), .c_in(c_in), .x_in(x_in),
      .busy(busy), .done(done), .result(result),
      .eval_go(eval_go), .eval_data(eval_data), .eval_result(eval_result)
   );

   // Evaluator stand-in: loads DataIn when Go is first sampled high, result appears
   // 5 edges after Go is sampled low following the fourth operand; synchronous reset.
   logic       ev_go_q;
   logic [7:0] ev_op [4];
   int         ev_n, ev_wait;
   always @(posedge clk) begin
      if (!resetn) begin
         ev_go_q     <= 1'b0;
         ev_n        <= 0;
         ev_wait     <= 0;
         eval_result <= '0;
      end else begin
         ev_go_q <= eval_go;
         if (eval_go && !ev_go_q && ev_n < 4) begin
            ev_op[ev_n] <= eval_data;
            ev_n        <= ev_n + 1;
         end
         if (!eval_go && ev_go_q && ev_n == 4) begin
            ev_wait     <= 5;
            eval_result <= 8'($urandom);
         end else if (ev_wait > 0) begin
            ev_wait <= ev_wait - 1;
            if (ev_wait == 1) begin
               eval_result <= 8'(ev_op[0] * ev_op[3] * ev_op[3] + ev_op[1] * ev_op[3] + ev_op[2]);
               ev_n        <= 0;
            end
         end
      end
   end

   function automatic logic [7:0] ref_poly(input int a, input int b, input int c, input int x);
      return 8'((a * x * x + b * x + c) & 255);
   endfunction

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask

   // Starts from an IDLE cycle; returns at posedge+1 of the cycle after done.
   task automatic run_txn(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                          input logic [7:0] x, input logic [7:0] req, input string name,
                          input bit hold, input bit inject);
      logic [7:0] ops [4];
      int lat, busy_cnt, wave_err;
      bit got;
      ops[0] = a; ops[1] = b; ops[2] = c; ops[3] = x;
      a_in = a; b_in = b; c_in = c; x_in = x;
      start = 1'b1;
      @(posedge clk); #1;
      start = hold;
      a_in = 8'($urandom); b_in = 8'($urandom); c_in = 8'($urandom); x_in = 8'($urandom);
      lat = 0; busy_cnt = 0; wave_err = 0; got = 1'b0;
      for (int n = 1; n <= 60 && !got; n++) begin
         @(negedge clk);
         if (done) begin
            got = 1'b1;
            lat = n;
            chk({name, " busy_at_done"}, int'(busy), 0);
            chk({name, " result"}, int'(result), int'(req));
         end else begin
            logic       exp_go;
            logic [7:0] exp_data;
            if (busy) busy_cnt++;
            if (n <= 4 * PER) begin
               exp_go   = ((n - 1) % PER) < HI;
               exp_data = ops[(n - 1) / PER];
            end else begin
               exp_go   = 1'b0;
               exp_data = 8'd0;
            end
            if (eval_go !== exp_go || eval_data !== exp_data) wave_err++;
         end
         @(posedge clk); #1;
         if (inject && (n + 1 == 3 || n + 1 == 10)) begin
            start = 1'b1;
            a_in = 8'($urandom); b_in = 8'($urandom); c_in = 8'($urandom); x_in = 8'($urandom);
         end else begin
            start = hold;
         end
      end
      chk({name, " done_seen"}, int'(got), 1);
      chk({name, " latency"}, lat, TOTAL);
      chk({name, " busy_cycles"}, busy_cnt, TOTAL - 1);
      chk({name, " go_data_wave"}, wave_err, 0);
   endtask

   typedef struct {
      logic [7:0] a, b, c, x, req;
   } vec_t;

   initial begin
      vec_t tbl [7];
      int   dones;
      tbl[0] = '{8'd2,   8'd3,   8'd4,   8'd5,   8'h45};
      tbl[1] = '{8'd3,   8'd0,   8'd255, 8'd10,  8'h2B};
      tbl[2] = '{8'd0,   8'd0,   8'd0,   8'd0,   8'h00};
      tbl[3] = '{8'd255, 8'd255, 8'd255, 8'd255, 8'hFF};
      tbl[4] = '{8'd1,   8'd1,   8'd1,   8'd1,   8'h03};
      tbl[5] = '{8'd16,  8'd16,  8'd16,  8'd16,  8'h10};
      tbl[6] = '{8'd7,   8'd2,   8'd9,   8'd3,   8'h4E};

      // reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst busy", int'(busy), 0);
      chk("rst done", int'(done), 0);
      chk("rst eval_go", int'(eval_go), 0);
      chk("rst eval_data", int'(eval_data), 0);
      chk("rst result", int'(result), 0);
      @(posedge clk); #1;
      resetn = 1'b1;
      @(posedge clk); #1;

      // table vectors, including the modular wrap cases
      for (int i = 0; i < 7; i++)
         run_txn(tbl[i].a, tbl[i].b, tbl[i].c, tbl[i].x, tbl[i].req,
                 $sformatf("tbl%0d", i), 1'b0, 1'b0);

      // start pulses while busy are ignored
      run_txn(8'd9, 8'd8, 8'd7, 8'd6, ref_poly(9, 8, 7, 6), "ignore_start", 1'b0, 1'b1);
      dones = 0;
      for (int i = 0; i < 25; i++) begin
         @(negedge clk);
         if (done) dones++;
      end
      chk("ignore_start extra_done", dones, 0);
      chk("ignore_start result_hold", int'(result), int'(ref_poly(9, 8, 7, 6)));

      // asynchronous reset in the middle of driving operand C
      @(posedge clk); #1;
      a_in = 8'd11; b_in = 8'd22; c_in = 8'd33; x_in = 8'd44;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (2 * PER) @(posedge clk);
      #1;
      chk("midrst pre_go", int'(eval_go), 1);
      chk("midrst pre_data", int'(eval_data), 33);
      #2;
      resetn = 1'b0;
      #1;
      chk("midrst busy", int'(busy), 0);
      chk("midrst eval_go", int'(eval_go), 0);
      chk("midrst eval_data", int'(eval_data), 0);
      chk("midrst result", int'(result), 0);
      dones = 0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (done) dones++;
      end
      @(posedge clk); #1;
      resetn = 1'b1;
      for (int i = 0; i < 25; i++) begin
         @(negedge clk);
         if (done) dones++;
      end
      chk("midrst no_done", dones, 0);
      @(posedge clk); #1;
      run_txn(8'd1, 8'd1, 8'd1, 8'd1, 8'd3, "after_rst", 1'b0, 1'b0);

      // back-to-back with start held high
      for (int i = 0; i < 4; i++) begin
         logic [7:0] a, b, c, x;
         a = 8'($urandom); b = 8'($urandom); c = 8'($urandom); x = 8'($urandom);
         run_txn(a, b, c, x, ref_poly(a, b, c, x), $sformatf("b2b%0d", i), 1'b1, 1'b0);
         @(negedge clk);
         chk($sformatf("b2b%0d idle_busy", i), int'(busy), 0);
         chk($sformatf("b2b%0d idle_done", i), int'(done), 0);
      end
      start = 1'b0;
      @(posedge clk); #1;
      repeat (TOTAL + 2) @(posedge clk);
      #1;

      // random transactions against the arithmetic reference
      for (int i = 0; i < 20; i++) begin
         logic [7:0] a, b, c, x;
         a = 8'($urandom); b = 8'($urandom); c = 8'($urandom); x = 8'($urandom);
         run_txn(a, b, c, x, ref_poly(a, b, c, x), $sformatf("rnd%0d", i), 1'b0, 1'b0);
         repeat ($urandom_range(0, 3)) @(posedge clk);
         #1;
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
